spram_ctrl: RTL and testbench

Request/response front-end for one SB_SPRAM256KA (16384 x 16) on the iCE40 UltraPlus. It sits directly upstream of the SPRAM primitive: it replaces ad-hoc address/data/WREN driving from a state machine with a valid/ready request port and a fixed-latency read-response strobe. On reset it clears the whole array, so consumers such as LED/colour sequencers never read uninitialised data.

---
 rtl/spram_pkg.sv | 28 ++
 rtl/spram_prim.sv | 49 ++++
 rtl/spram_ctrl.sv | 156 +++++++++++++++
 tb/tb_spram_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// spram_pkg: shared constants, state encoding and mask helper for the
// SPRAM request/response controller.
package spram_pkg;

   localparam int SPRAM_AW     = 14;
   localparam int SPRAM_DW     = 16;
   localparam int SPRAM_DEPTH  = 16384;
   localparam int SPRAM_RD_LAT = 2;

   // Word written to every address during the power-up clear.
   localparam logic [SPRAM_DW-1:0] CLEAR_VALUE = 16'h0000;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Expand a 4-bit nibble write-enable into a 16-bit bit mask.
   function automatic logic [SPRAM_DW-1:0] nibble_bitmask(input logic [3:0] mask);
      logic [SPRAM_DW-1:0] bm;
      bm = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         bm[4*i +: 4] = {4{mask[i]}};
      end
      return bm;
   endfunction

endpackage

// File: rtl/spram_prim.sv
// spram_prim: thin wrapper around one SB_SPRAM256KA with fixed tie-offs
// (CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1). Define SPRAM_PRIM_ICE40
// to instantiate the vendor primitive; otherwise a behavioural model with
// the same 1-cycle registered read latency and nibble write mask is built.
module spram_prim
   import spram_pkg::*;
(
   input  logic                i_clk,
   input  logic [SPRAM_AW-1:0] i_addr,
   input  logic [SPRAM_DW-1:0] i_wdata,
   input  logic [3:0]          i_mask,
   input  logic                i_wren,
   output logic [SPRAM_DW-1:0] o_rdata
);

`ifdef SPRAM_PRIM_ICE40
   SB_SPRAM256KA u_spram (
      .ADDRESS    (i_addr),
      .DATAIN     (i_wdata),
      .MASKWREN   (i_mask),
      .WREN       (i_wren),
      .CHIPSELECT (1'b1),
      .CLOCK      (i_clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (o_rdata)
   );
`else
   logic [SPRAM_DW-1:0] r_mem [0:SPRAM_DEPTH-1];
   logic [SPRAM_DW-1:0] r_rdata;
   logic [SPRAM_DW-1:0] w_bitmask;

   assign w_bitmask = nibble_bitmask(i_mask);

   // Masked write on WREN, otherwise register the addressed word; the
   // output holds its value across write cycles like the primitive.
   always_ff @(posedge i_clk) begin
      if (i_wren) begin
         r_mem[i_addr] <= (r_mem[i_addr] & ~w_bitmask) | (i_wdata & w_bitmask);
      end else begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/spram_ctrl.sv
// spram_ctrl: valid/ready request front-end for one SPRAM with a fixed
// 2-cycle read-response strobe. Define SPRAM_CTRL_CLEAR_EN to build the
// power-up clear that writes CLEAR_VALUE to every address before RUN.
module spram_ctrl
   import spram_pkg::*;
(
   input  logic                CLK,
   input  logic                RESETN,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [SPRAM_AW-1:0] req_addr,
   input  logic [SPRAM_DW-1:0] req_wdata,
   input  logic [3:0]          req_mask,
   output logic                rsp_valid,
   output logic [SPRAM_DW-1:0] rsp_rdata,
   output logic                init_done
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_ready;
   logic                    w_ready_nxt;
   logic [SPRAM_AW-1:0]     r_addr;
   logic [SPRAM_DW-1:0]     r_wdata;
   logic [3:0]              r_mask;
   logic                    r_wren;
   logic [SPRAM_RD_LAT-1:0] r_rd_pipe;
   logic                    r_rsp_valid;
   logic [SPRAM_DW-1:0]     r_rsp_rdata;
   logic [SPRAM_DW-1:0]     w_prim_rdata;
   logic                    w_accept;
   logic                    w_clr_issue;
   logic                    w_clr_last;
   logic [SPRAM_AW-1:0]     w_clr_addr;

   assign w_accept = req_valid & r_ready;

`ifdef SPRAM_CTRL_CLEAR_EN
   logic [SPRAM_AW-1:0] r_clr_addr;

   assign w_clr_addr  = r_clr_addr;
   assign w_clr_last  = (r_clr_addr == 14'(SPRAM_DEPTH - 1));
   assign w_clr_issue = (r_state == CLEAR);

   // Clear address counter: advances once per CLEAR cycle and parks on the
   // last address; only reset brings it back to 0.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_clr_addr <= 14'd0;
      end else if (w_clr_issue && !w_clr_last) begin
         r_clr_addr <= r_clr_addr + 14'd1;
      end else begin
         r_clr_addr <= r_clr_addr;
      end
   end
`else
   assign w_clr_addr  = 14'd0;
   assign w_clr_last  = 1'b1;
   assign w_clr_issue = 1'b0;
`endif

   // Next-state and ready/init decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ready_nxt = 1'b0;
      case (r_state)
         CLEAR: begin
            if (w_clr_last) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = CLEAR;
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = CLEAR;
         end
      endcase
`ifdef SPRAM_CTRL_CLEAR_EN
      // Ready follows the edge after the final clear write is issued.
      w_ready_nxt = (r_state == RUN);
`else
      w_ready_nxt = (w_state_nxt == RUN);
`endif
   end

   // State and ready/init_done registers.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state <= CLEAR;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   // SPRAM port registers: clear writes take priority, then accepted requests.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_addr  <= 14'd0;
         r_wdata <= 16'h0000;
         r_mask  <= 4'b0000;
         r_wren  <= 1'b0;
      end else if (w_clr_issue) begin
         r_addr  <= w_clr_addr;
         r_wdata <= CLEAR_VALUE;
         r_mask  <= 4'b1111;
         r_wren  <= 1'b1;
      end else if (w_accept) begin
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_mask  <= req_we ? req_mask : 4'b0000;
         r_wren  <= req_we;
      end else begin
         r_mask  <= 4'b0000;
         r_wren  <= 1'b0;
      end
   end

   // Read-valid shift register plus registered response; reset drops
   // anything in flight.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_rd_pipe   <= 2'b00;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 16'h0000;
      end else begin
         r_rd_pipe   <= {r_rd_pipe[0], w_accept & ~req_we};
         r_rsp_valid <= r_rd_pipe[1];
         if (r_rd_pipe[1]) begin
            r_rsp_rdata <= w_prim_rdata;
         end else begin
            r_rsp_rdata <= r_rsp_rdata;
         end
      end
   end

   spram_prim u_prim (
      .i_clk   (CLK),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .i_mask  (r_mask),
      .i_wren  (r_wren),
      .o_rdata (w_prim_rdata)
   );

   assign req_ready = r_ready;
   assign init_done = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: directed stimulus with a scoreboard queue of expected read
// data and accept cycles; a negedge monitor pops and compares on rsp_valid.
// Honours SPRAM_CTRL_CLEAR_EN for the clear-duration expectations.
module tb_spram_ctrl;

`ifdef SPRAM_CTRL_CLEAR_EN
   localparam int INIT_EDGES = 16385;
`else
   localparam int INIT_EDGES = 1;
`endif

   logic        CLK;
   logic        RESETN;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [13:0] req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_mask;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        init_done;

   int          n_pass;
   int          n_total;
   int          cyc;
   int          n_rsp_seen;
   int          n_rsp_exp;
   logic [15:0] exp_q[$];
   int          cyc_q[$];

   spram_ctrl dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_mask  (req_mask),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: pop expected data and accept cycle on each response strobe.
   always @(negedge CLK) begin
      logic [15:0] d;
      int          c;
      if (RESETN && rsp_valid) begin
         n_rsp_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            d = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("rsp_rdata", {16'h0000, rsp_rdata}, {16'h0000, d});
            chk("rsp_latency", 32'(cyc - c), 32'd2);
         end
      end
   end

   task automatic issue(input logic we, input logic [13:0] a, input logic [15:0] d,
                        input logic [3:0] m, input logic [15:0] exp);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_mask  = m;
      @(posedge CLK);
      #1;
      if (!we) begin
         exp_q.push_back(exp);
         cyc_q.push_back(cyc);
         n_rsp_exp++;
      end
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
      issue(1'b1, a, d, m, 16'h0000);
   endtask

   task automatic rd(input logic [13:0] a, input logic [15:0] exp);
      issue(1'b0, a, 16'h0000, 4'b0000, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      RESETN    = 1'b0;
      req_valid = 1'b0;
      n_rsp_exp = n_rsp_exp - exp_q.size();
      exp_q.delete();
      cyc_q.delete();
      idle(3);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {16'h0000, rsp_rdata}, 32'h0000_0000);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
   endtask

   task automatic release_and_measure(input int exp_edges);
      int k_ready;
      int k_done;
      k_ready = 0;
      k_done  = 0;
      @(negedge CLK);
      RESETN = 1'b1;
      for (int k = 1; k <= 20000; k++) begin
         @(posedge CLK);
         #1;
         if (k_ready == 0 && req_ready) k_ready = k;
         if (k_done == 0 && init_done) k_done = k;
         if (k_ready != 0 && k_done != 0) break;
      end
      chk("init_done_edge", 32'(k_done), 32'(exp_edges));
      chk("req_ready_edge", 32'(k_ready), 32'(exp_edges));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0; n_total = 0; n_rsp_seen = 0; n_rsp_exp = 0;
      RESETN = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 14'd0; req_wdata = 16'h0000; req_mask = 4'b0000;
      idle(2);
      reset_dut();
      release_and_measure(INIT_EDGES);

`ifdef SPRAM_CTRL_CLEAR_EN
      rd(14'd0, 16'h0000);
      rd(14'd8191, 16'h0000);
      rd(14'd16383, 16'h0000);
`endif
      // Back-to-back writes then back-to-back reads.
      wr(14'd0, 16'h0001, 4'b1111);
      wr(14'd1, 16'h0002, 4'b1111);
      wr(14'd2, 16'h0004, 4'b1111);
      wr(14'd3, 16'h0007, 4'b1111);
      rd(14'd0, 16'h0001);
      rd(14'd1, 16'h0002);
      rd(14'd2, 16'h0004);
      rd(14'd3, 16'h0007);
      idle(4);
      // Nibble mask 0101 enables [3:0] and [11:8]: FFFF over ABCD -> FBFD.
      wr(14'd5, 16'hFFFF, 4'b1111);
      wr(14'd5, 16'hABCD, 4'b0101);
      rd(14'd5, 16'hFBFD);
      // All-zero mask leaves memory unchanged.
      wr(14'd6, 16'h1111, 4'b1111);
      wr(14'd6, 16'h2222, 4'b0000);
      rd(14'd6, 16'h1111);
      // Read-after-write on consecutive cycles.
      wr(14'd9, 16'h1234, 4'b1111);
      rd(14'd9, 16'h1234);
      wr(14'd16383, 16'h00AA, 4'b1111);
      rd(14'd16383, 16'h00AA);
      // Interleaved reads and writes.
      rd(14'd0, 16'h0001);
      wr(14'd0, 16'h5555, 4'b1111);
      rd(14'd0, 16'h5555);
      rd(14'd3, 16'h0007);
      idle(6);

      // Reset with a read in flight: its response must be dropped.
      rd(14'd1, 16'h0002);
      reset_dut();
`ifdef SPRAM_CTRL_CLEAR_EN
      // Reset again part-way through the clear (around clr_addr 100).
      @(negedge CLK);
      RESETN = 1'b1;
      idle(100);
      reset_dut();
`endif
      release_and_measure(INIT_EDGES);
`ifdef SPRAM_CTRL_CLEAR_EN
      rd(14'd0, 16'h0000);
      rd(14'd16383, 16'h0000);
`else
      rd(14'd16383, 16'h00AA);
`endif
      idle(6);
      chk("rsp_count", 32'(n_rsp_seen), 32'(n_rsp_exp));
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
